// File: rtl/multirate_v4_tap_accum.sv
// multirate_v4_tap_accum
//   Sums one tap group of signed products (one polyphase output sample),
//   then rounds (half toward +inf), shifts by SHIFT and saturates the sum to
//   OUT_W bits. The result sits in a valid/ready output register. One output
//   is produced per group, so the block also decimates.
// Ports:
//   ap_clk, ap_rst   clock, synchronous active-high reset
//   prod_data        signed product from the coefficient multiplier
//   prod_valid       product present
//   prod_last        final product of the group (qualified by prod_valid)
//   prod_ready       block accepts a product this cycle
//   out_data         rounded/saturated output sample
//   out_valid        out_data valid
//   out_ready        downstream accepts the sample
//   out_sat          sample was clipped (valid with out_valid)
//   grp_err          sticky: a group reached MAX_TAPS without prod_last
module multirate_v4_tap_accum #(
   parameter int PROD_W   = 26,
   parameter int OUT_W    = 16,
   parameter int MAX_TAPS = 64,
   parameter int SHIFT    = 9
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic signed [PROD_W-1:0] prod_data,
   input  logic                     prod_valid,
   input  logic                     prod_last,
   output logic                     prod_ready,
   output logic        [OUT_W-1:0]  out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_sat,
   output logic                     grp_err
);

   localparam int ACC_W = PROD_W + $clog2(MAX_TAPS);
   localparam int CNT_W = $clog2(MAX_TAPS + 1);

   localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(1) << (SHIFT - 1);
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic {IDLE, ACC} state_t;

   state_t                    state, state_nxt;
   logic signed [ACC_W-1:0]   acc, acc_nxt;
   logic        [CNT_W-1:0]   count, count_nxt;

   logic                      fire;
   logic                      close;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   sum;
   logic signed [ACC_W:0]     sum_rnd;
   logic signed [ACC_W:0]     r;
   logic        [OUT_W-1:0]   res_data;
   logic                      res_sat;

   // datapath: closing sum, rounding and saturation
   always_comb begin
      prod_ready = !out_valid || out_ready;
      fire       = prod_valid && prod_ready;
      prod_ext   = ACC_W'(prod_data);
      // acc is zero in IDLE, so the same adder serves both states
      sum        = acc + prod_ext;
      // one extra bit so adding the rounding constant cannot wrap
      sum_rnd    = (ACC_W+1)'(sum) + RND;
      r          = sum_rnd >>> SHIFT;
      close      = fire && (prod_last || (count == CNT_W'(MAX_TAPS - 1)));
      res_sat    = 1'b0;
      res_data   = r[OUT_W-1:0];
      if (r > SAT_MAX) begin
         res_data = SAT_MAX[OUT_W-1:0];
         res_sat  = 1'b1;
      end else if (r < SAT_MIN) begin
         res_data = SAT_MIN[OUT_W-1:0];
         res_sat  = 1'b1;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      count_nxt = count;
      case (state)
         IDLE: begin
            if (fire && !close) begin
               acc_nxt   = prod_ext;
               count_nxt = CNT_W'(1);
               state_nxt = ACC;
            end
         end
         ACC: begin
            if (close) begin
               acc_nxt   = '0;
               count_nxt = '0;
               state_nxt = IDLE;
            end else if (fire) begin
               acc_nxt   = sum;
               count_nxt = count + CNT_W'(1);
            end
         end
         default: begin
            acc_nxt   = '0;
            count_nxt = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         grp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         count <= count_nxt;
         // a close can only fire when the register is empty or draining,
         // so reloading here also covers handshake-and-close in one cycle
         if (close) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_sat   <= res_sat;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (close && !prod_last)
            grp_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multirate_v4_tap_accum.sv
// Testbench for multirate_v4_tap_accum: scoreboard of expected samples,
// pushed when a group is closed and popped when the output handshakes.
module tb_multirate_v4_tap_accum;

   localparam int PROD_W = 26;
   localparam int OUT_W  = 16;
   localparam int SHIFT  = 9;

   logic                     ap_clk = 1'b0;
   logic                     ap_rst;
   logic signed [PROD_W-1:0] prod_data;
   logic                     prod_valid;
   logic                     prod_last;
   logic                     prod_ready;
   logic        [OUT_W-1:0]  out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_sat;
   logic                     grp_err;

   int errors = 0;
   int checks = 0;
   logic [OUT_W:0] sb[$];   // {sat, data}

   multirate_v4_tap_accum #(
      .PROD_W(PROD_W), .OUT_W(OUT_W), .MAX_TAPS(64), .SHIFT(SHIFT)
   ) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .prod_data(prod_data), .prod_valid(prod_valid), .prod_last(prod_last),
      .prod_ready(prod_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sat(out_sat), .grp_err(grp_err)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [OUT_W:0] model(input longint s);
      longint r;
      r = (s + longint'(2 ** (SHIFT - 1))) >>> SHIFT;
      if (r > 32767)       return {1'b1, 16'sd32767};
      else if (r < -32768) return {1'b1, 16'h8000};
      else                 return {1'b0, r[15:0]};
   endfunction

   task automatic push(input longint d, input bit s);
      logic [63:0] v;
      v = d;
      sb.push_back({s, v[15:0]});
   endtask

   // inputs change at posedge+1, ready sampled on the preceding negedge
   task automatic beat(input longint d, input bit l);
      bit ok;
      logic [63:0] v;
      ok = 1'b0;
      v = d;
      prod_data  = v[PROD_W-1:0];
      prod_valid = 1'b1;
      prod_last  = l;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge ap_clk);
         ok = prod_ready;
         @(posedge ap_clk); #1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      prod_valid = 1'b0;
      prod_last  = 1'b0;
   endtask

   // output monitor
   always @(negedge ap_clk) begin
      logic [OUT_W:0] e;
      if (!ap_rst && out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_out", $signed(out_data), 0);
         else begin
            e = sb.pop_front();
            chk("out_data", longint'($signed(out_data)), longint'($signed(e[OUT_W-1:0])));
            chk("out_sat", out_sat, e[OUT_W]);
         end
      end
   end

   initial begin
      longint sum;
      int     n, p;
      ap_rst = 1'b1; prod_valid = 1'b0; prod_last = 1'b0; prod_data = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge ap_clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_grp_err", grp_err, 0);
      chk("rst_prod_ready", prod_ready, 1);
      ap_rst = 1'b0;
      out_ready = 1'b1;

      // basic 4-beat group, latency one cycle
      for (int i = 0; i < 4; i++) beat(512000, i == 3);
      push(4000, 0);
      chk("latency_valid", out_valid, 1);

      // rounding on 1-tap groups, back to back
      beat(256, 1);  push(1, 0);
      beat(255, 1);  push(0, 0);
      beat(-256, 1); push(0, 0);
      beat(-257, 1); push(-1, 0);

      // saturation
      for (int i = 0; i < 4; i++) beat(33520641, i == 3);
      push(32767, 1);
      for (int i = 0; i < 4; i++) beat(-33521664, i == 3);
      push(-32768, 1);
      repeat (3) @(posedge ap_clk);
      #1;

      // backpressure
      out_ready = 1'b0;
      beat(1024, 1); push(2, 0);
      prod_data = 512; prod_valid = 1'b1; prod_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge ap_clk);
         chk("bp_prod_ready", prod_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_data", out_data, 2);
         @(posedge ap_clk); #1;
      end
      out_ready = 1'b1;
      push(1, 0);
      @(negedge ap_clk);
      chk("bp_release_ready", prod_ready, 1);
      @(posedge ap_clk); #1;
      chk("bp_reload_valid", out_valid, 1);
      chk("bp_reload_data", out_data, 1);
      prod_valid = 1'b0; prod_last = 1'b0;
      repeat (2) @(posedge ap_clk);
      #1;

      // MAX_TAPS close without last
      chk("grp_err_before", grp_err, 0);
      for (int i = 0; i < 64; i++) beat(1000, 0);
      push(125, 0);
      chk("grp_err_set", grp_err, 1);
      beat(512, 1); push(1, 0);
      repeat (2) @(posedge ap_clk);
      #1;
      chk("grp_err_sticky", grp_err, 1);

      // reset mid-group
      beat(512, 0);
      beat(512, 0);
      ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_out_sat", out_sat, 0);
      chk("mid_rst_grp_err", grp_err, 0);
      ap_rst = 1'b0;
      beat(512, 0);
      beat(512, 1);
      push(2, 0);

      // random groups checked against the arithmetic model
      for (int g = 0; g < 24; g++) begin
         n = $urandom_range(1, 8);
         sum = 0;
         for (int k = 0; k < n; k++) begin
            if (g % 2 == 1) p = int'($urandom_range(0, 67108862)) - 33554431;
            else            p = int'($urandom_range(0, 2097151)) - 1048576;
            sum += p;
            beat(p, k == n - 1);
         end
         sb.push_back(model(sum));
      end

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge ap_clk);
      #1;
      chk("drain_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multirate_v4_tap_accum.md
# multirate_v4_tap_accum

Tap accumulator for the multirate FIR filterbank, directly downstream of the 16s×10u→26s coefficient multiplier. It sums one tap group of signed 26-bit products (one polyphase output sample), then rounds, shifts and saturates the sum to a 16-bit signed sample. The result is presented on a valid/ready output register to the next rate stage. One output is produced per tap group, so this block also performs the decimation.

## Interface
- `PROD_W`, 26: signed product width from the multiplier.
- `OUT_W`, 16: signed output sample width.
- `MAX_TAPS`, 64: maximum products per group; counter width clog2(MAX_TAPS+1).
- `SHIFT`, 9: coefficient fraction bits removed at output; must be ≥1.
- `ACC_W`, PROD_W+clog2(MAX_TAPS) (32): accumulator width, derived, not overridden.
- `ap_clk`  in  1  clock; all logic rising-edge.
- `ap_rst`  in  1  synchronous, active-high reset.
- `prod_data`  in  PROD_W  signed product.
- `prod_valid`  in  1  product present.
- `prod_last`  in  1  final product of current tap group; qualified by `prod_valid`.
- `prod_ready`  out  1  block accepts product this cycle.
- `out_data`  out  OUT_W  rounded/saturated sample.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts sample.
- `out_sat`  out  1  sample was clipped; valid with `out_valid`.
- `grp_err`  out  1  sticky: a group hit MAX_TAPS without `prod_last`.

## Operation
- Beat accepted when `prod_valid && prod_ready`. `prod_ready = !out_valid || out_ready` (combinational).
- FSM states:
  - IDLE: acc empty, count 0. A non-last beat loads acc=prod, count=1, then goes to ACC. A last beat closes a 1-tap group.
  - ACC: non-last beat adds the product, count+1. A beat closes the group when it is last or count+1==MAX_TAPS. On close: acc cleared, count 0, return to IDLE.
- Close without `prod_last` (count reached MAX_TAPS) sets `grp_err`. `grp_err` is cleared only by reset.
- Close computes sum = acc + prod_data, full ACC_W, sign-extended. No intermediate wrap is possible by the width rule.
- Rounding: r = (sum + 2^(SHIFT-1)) >>> SHIFT (round half toward +∞), evaluated at ACC_W+1 bits.
- Saturation: r clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. `out_sat`=1 iff clamped.
- Output register loads `out_data`/`out_sat` and sets `out_valid` on the cycle after the closing beat. It holds while `out_valid && !out_ready`. `out_valid` clears on handshake unless a new close occurs in the same cycle, in which case the register reloads and `out_valid` stays 1.
- Simultaneous output handshake and input beat is legal in every state. No bubble is inserted.
- `prod_last` with `prod_valid`=0 is ignored.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sat`=0, `grp_err`=0, acc=0, count=0, state IDLE. After reset, `prod_ready`=1.
- Latency: closing beat accepted at cycle N → `out_valid`=1 at N+1.
- Throughput: one product per cycle. With `out_ready` held high, back-to-back 1-tap groups produce one output per cycle.
- Backpressure: while `out_valid && !out_ready`, `prod_ready`=0. acc, count and state freeze; partial groups are preserved.
- Reset asserted mid-group or with output pending discards the partial sum and the pending sample. No output is emitted for that group.
- `out_data`/`out_sat` stable while `out_valid && !out_ready`.

## Test plan
- Four beats of 512000 (1000×512), last on the 4th, `out_ready`=1 → `out_data`=4000 one cycle after the 4th beat; `out_sat`=0.
- Rounding, 1-tap groups with `prod_last`=1:
  - 256 → 1
  - 255 → 0
  - −256 → 0
  - −257 → −1
  - all with `out_sat`=0.
- Saturation:
  - Four beats of 33520641 (32767×1023) → 32767, `out_sat`=1.
  - Four beats of −33521664 → −32768, `out_sat`=1.
- Backpressure:
  - Close a group with `out_ready`=0 for 5 cycles while `prod_valid`=1 → `prod_ready`=0 and `out_data` stable for those 5 cycles.
  - Raise `out_ready` → handshake, and the next beat is accepted in the same cycle.
- 64 beats of 1000 with no `prod_last` → output (64000+256)>>>9=125 after the 64th beat; `grp_err`=1 and stays 1 across later groups.
- Assert `ap_rst` for one cycle after 2 of 4 beats, then send a fresh 2-beat group of 512 → single output 2. All outputs read reset values during the reset cycle.
